// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/mem-wait hazard and forwarding control; optional HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int REG_AW          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [6:0]        id_opcode_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              ex_br_taken_i,
    input  logic              mem_ready_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              flush_id_o,
    output logic              bubble_ex_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Remaining stall cycles after the first (detection) cycle.
    localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t state_q, state_nxt;
    logic [1:0] cnt_q, cnt_nxt;

    // Shadow of the instructions in EX and MEM. The WB slot needs no copy:
    // register-file write-through covers a WB producer.
    logic              ex_vld, ex_wr, ex_ld;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_vld, mem_wr;
    logic [REG_AW-1:0] mem_rd;

    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;

    logic id_writes, uses_rs1, uses_rs2, id_is_load, hz;
    logic advance, lu_stall_cyc;
    logic stall_c, flush_c, bubble_c;

    // Opcode class decode of the ID instruction; rd=0 never counts as a write.
    always_comb begin
        id_writes  = (id_opcode_i != OP_STORE) && (id_opcode_i != OP_BRANCH) &&
                     (id_rd_i != '0);
        uses_rs1   = (id_opcode_i == OP_R) || (id_opcode_i == OP_I) ||
                     (id_opcode_i == OP_LOAD) || (id_opcode_i == OP_STORE) ||
                     (id_opcode_i == OP_BRANCH) || (id_opcode_i == OP_JALR);
        uses_rs2   = (id_opcode_i == OP_R) || (id_opcode_i == OP_STORE) ||
                     (id_opcode_i == OP_BRANCH);
        id_is_load = (id_opcode_i == OP_LOAD);
        hz = id_valid_i && ex_vld && ex_ld && (ex_rd != '0) &&
             ((uses_rs1 && (id_rs1_i == ex_rd)) || (uses_rs2 && (id_rs2_i == ex_rd)));
    end

    // Stall/flush FSM next-state and combinational controls; mem wait > branch > load-use.
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        stall_c      = 1'b0;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        advance      = 1'b0;
        lu_stall_cyc = 1'b0;
        if (!rst_n) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else if (!mem_ready_i) begin
            stall_c = 1'b1;
        end else if (ex_br_taken_i) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
        end else if (state_q == LU_STALL) begin
            stall_c      = 1'b1;
            bubble_c     = 1'b1;
            lu_stall_cyc = 1'b1;
            if (cnt_q <= 2'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end else begin
                cnt_nxt = cnt_q - 2'd1;
            end
        end else if (hz) begin
            stall_c      = 1'b1;
            bubble_c     = 1'b1;
            lu_stall_cyc = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                state_nxt = LU_STALL;
                cnt_nxt   = LU_INIT;
            end
        end else begin
            advance = id_valid_i;
        end
    end

    // Forwarding select for the ID instruction; EX/MEM (newest) beats MEM/WB.
    always_comb begin
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (uses_rs1 && (id_rs1_i != '0)) begin
            if (ex_vld && ex_wr && (ex_rd == id_rs1_i))
                fwd_a_nxt = 2'b01;
            else if (mem_vld && mem_wr && (mem_rd == id_rs1_i))
                fwd_a_nxt = 2'b10;
        end
        if (uses_rs2 && (id_rs2_i != '0)) begin
            if (ex_vld && ex_wr && (ex_rd == id_rs2_i))
                fwd_b_nxt = 2'b01;
            else if (mem_vld && mem_wr && (mem_rd == id_rs2_i))
                fwd_b_nxt = 2'b10;
        end
    end

    // State, scoreboard and forwarding registers; everything holds while memory waits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            ex_vld  <= 1'b0;
            ex_wr   <= 1'b0;
            ex_ld   <= 1'b0;
            ex_rd   <= '0;
            mem_vld <= 1'b0;
            mem_wr  <= 1'b0;
            mem_rd  <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (mem_ready_i) begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            mem_vld <= ex_vld;
            mem_wr  <= ex_wr;
            mem_rd  <= ex_rd;
            if (advance) begin
                ex_vld  <= 1'b1;
                ex_wr   <= id_writes;
                ex_ld   <= id_is_load;
                ex_rd   <= id_rd_i;
                fwd_a_q <= fwd_a_nxt;
                fwd_b_q <= fwd_b_nxt;
            end else begin
                ex_vld  <= 1'b0;
                ex_wr   <= 1'b0;
                ex_ld   <= 1'b0;
                ex_rd   <= '0;
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end
        end
    end

    assign stall_if_o  = stall_c;
    assign stall_id_o  = stall_c;
    assign flush_id_o  = flush_c;
    assign bubble_ex_o = bubble_c;
    assign fwd_a_sel_o = rst_n ? fwd_a_q : 2'b00;
    assign fwd_b_sel_o = rst_n ? fwd_b_q : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of unfrozen load-use stall cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (lu_stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_c && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed + random bench for pipeline_hazard_ctrl (LU_STALL_CYCLES 1 and 2)
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst_n, id_valid, br, mr;
    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;

    logic       o_sif [2];
    logic       o_sid [2];
    logic       o_fl  [2];
    logic       o_bub [2];
    logic [1:0] o_fa  [2];
    logic [1:0] o_fb  [2];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] o_sc [2];
    logic [31:0] o_fc [2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .REG_AW(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_opcode_i(opc),
        .id_rd_i(rd), .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_br_taken_i(br),
        .mem_ready_i(mr), .stall_if_o(o_sif[0]), .stall_id_o(o_sid[0]),
        .flush_id_o(o_fl[0]), .bubble_ex_o(o_bub[0]), .fwd_a_sel_o(o_fa[0]),
        .fwd_b_sel_o(o_fb[0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(o_sc[0]), .flush_cnt_o(o_fc[0])
`endif
    );

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(2), .REG_AW(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_opcode_i(opc),
        .id_rd_i(rd), .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_br_taken_i(br),
        .mem_ready_i(mr), .stall_if_o(o_sif[1]), .stall_id_o(o_sid[1]),
        .flush_id_o(o_fl[1]), .bubble_ex_o(o_bub[1]), .fwd_a_sel_o(o_fa[1]),
        .fwd_b_sel_o(o_fb[1])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(o_sc[1]), .flush_cnt_o(o_fc[1])
`endif
    );

    // Reference model: in-flight instructions kept as raw opcode/rd, plus a
    // count of load-use stall cycles still owed.
    logic       m_ex_v [2];
    logic [6:0] m_ex_op [2];
    logic [4:0] m_ex_rd [2];
    logic       m_mem_v [2];
    logic [6:0] m_mem_op [2];
    logic [4:0] m_mem_rd [2];
    int         m_left [2];
    logic [1:0] m_fa [2];
    logic [1:0] m_fb [2];
    int         m_sc [2];
    int         m_fc [2];

    function automatic logic writes(input logic [6:0] op);
        return (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    function automatic logic reads1(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE ||
               op == OP_BRANCH || op == OP_JALR;
    endfunction

    function automatic logic reads2(input logic [6:0] op);
        return op == OP_R || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic m_hz(input int k);
        logic needs_ex;
        needs_ex = (reads1(opc) && rs1 == m_ex_rd[k]) || (reads2(opc) && rs2 == m_ex_rd[k]);
        return id_valid && m_ex_v[k] && m_ex_op[k] == OP_LOAD && m_ex_rd[k] != 0 && needs_ex;
    endfunction

    function automatic logic [1:0] m_sel(input int k, input logic used, input logic [4:0] rs);
        if (!used || rs == 0) return 2'b00;
        if (m_ex_v[k] && writes(m_ex_op[k]) && m_ex_rd[k] == rs) return 2'b01;
        if (m_mem_v[k] && writes(m_mem_op[k]) && m_mem_rd[k] == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear(input int k);
        m_ex_v[k] = 0; m_ex_op[k] = '0; m_ex_rd[k] = '0;
        m_mem_v[k] = 0; m_mem_op[k] = '0; m_mem_rd[k] = '0;
        m_left[k] = 0; m_fa[k] = 2'b00; m_fb[k] = 2'b00;
        m_sc[k] = 0; m_fc[k] = 0;
    endtask

    // One clock: drive, check mid-cycle against the model, clock, advance the model.
    task automatic step(input logic r, input logic v, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic t, input logic m);
        logic e_st, e_fl, e_bu, h, adv;
        int lu;
        rst_n = r; id_valid = v; opc = op; rd = d; rs1 = a; rs2 = b; br = t; mr = m;
        #4;
        for (int k = 0; k < 2; k++) begin
            h = m_hz(k);
            e_st = 0; e_fl = 0; e_bu = 0;
            if (!r) begin
            end else if (!m) e_st = 1;
            else if (t) begin e_fl = 1; e_bu = 1; end
            else if (m_left[k] > 0 || h) begin e_st = 1; e_bu = 1; end
            chk($sformatf("u%0d.stall_if", k), 32'(o_sif[k]), 32'(e_st));
            chk($sformatf("u%0d.stall_id", k), 32'(o_sid[k]), 32'(e_st));
            chk($sformatf("u%0d.flush_id", k), 32'(o_fl[k]), 32'(e_fl));
            chk($sformatf("u%0d.bubble_ex", k), 32'(o_bub[k]), 32'(e_bu));
            chk($sformatf("u%0d.fwd_a", k), 32'(o_fa[k]), r ? 32'(m_fa[k]) : 32'd0);
            chk($sformatf("u%0d.fwd_b", k), 32'(o_fb[k]), r ? 32'(m_fb[k]) : 32'd0);
`ifdef HAZARD_PERF_CNT_EN
            chk($sformatf("u%0d.stall_cnt", k), o_sc[k], 32'(m_sc[k]));
            chk($sformatf("u%0d.flush_cnt", k), o_fc[k], 32'(m_fc[k]));
`endif
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            lu = (k == 0) ? 1 : 2;
            h = m_hz(k);
            if (!r) m_clear(k);
            else if (m) begin
                adv = v && !t && m_left[k] == 0 && !h;
                m_fa[k] = adv ? m_sel(k, reads1(op), a) : 2'b00;
                m_fb[k] = adv ? m_sel(k, reads2(op), b) : 2'b00;
                if (t) m_fc[k]++;
                else if (m_left[k] > 0 || h) m_sc[k]++;
                if (t) m_left[k] = 0;
                else if (m_left[k] > 0) m_left[k]--;
                else if (h) m_left[k] = lu - 1;
                m_mem_v[k] = m_ex_v[k]; m_mem_op[k] = m_ex_op[k]; m_mem_rd[k] = m_ex_rd[k];
                m_ex_v[k] = adv; m_ex_op[k] = op; m_ex_rd[k] = d;
            end
        end
        #1;
    endtask

    task automatic ins(input logic [6:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        step(1, 1, op, d, a, b, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, OP_I, 0, 0, 0, 0, 1);
    endtask

    logic [6:0] ops [8];

    initial begin
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE;
        ops[4] = OP_BRANCH; ops[5] = OP_JALR; ops[6] = OP_JAL; ops[7] = OP_LUI;
        for (int k = 0; k < 2; k++) m_clear(k);
        rst_n = 0; id_valid = 0; opc = '0; rd = '0; rs1 = '0; rs2 = '0; br = 0; mr = 1;
        @(posedge clk); #1;

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            step(0, 1'($urandom), ops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom),
                 5'($urandom), 1'($urandom), 1'($urandom));
        ins(OP_R, 1, 2, 3);
        chk("first_fwd_a", 32'(o_fa[0]), 32'd0);
        chk("first_fwd_b", 32'(o_fb[0]), 32'd0);
        idle(3);

        // Load-use: lw x5 ; add x6,x5,x7
        ins(OP_LOAD, 5, 1, 0);
        ins(OP_R, 6, 5, 7);
        ins(OP_R, 6, 5, 7);
        chk("lu_fwd_a", 32'(o_fa[0]), 32'd2);
        chk("lu_fwd_b", 32'(o_fb[0]), 32'd0);
        idle(3);

        // ALU chain
        ins(OP_R, 5, 1, 2);
        ins(OP_R, 6, 5, 5);
        chk("alu_fwd_a", 32'(o_fa[1]), 32'd1);
        chk("alu_fwd_b", 32'(o_fb[1]), 32'd1);
        ins(OP_R, 7, 5, 0);
        chk("alu3_fwd_a", 32'(o_fa[1]), 32'd2);
        idle(3);

        // x0 and class filtering
        ins(OP_LOAD, 0, 1, 0);
        ins(OP_R, 1, 0, 0);
        chk("x0_fwd_a", 32'(o_fa[0]), 32'd0);
        idle(3);
        ins(OP_STORE, 5, 2, 3);
        ins(OP_R, 1, 5, 5);
        chk("sw_fwd_a", 32'(o_fa[0]), 32'd0);
        chk("sw_fwd_b", 32'(o_fb[0]), 32'd0);
        idle(3);

        // Branch collides with load-use
        ins(OP_LOAD, 5, 1, 0);
        step(1, 1, OP_R, 6, 5, 5, 1, 1);
        ins(OP_R, 6, 5, 5);
        chk("br_fwd_a", 32'(o_fa[1]), 32'd2);
        idle(3);

        // Frozen stall in the 2-cycle build
        ins(OP_LOAD, 5, 1, 0);
        ins(OP_R, 6, 5, 5);
        for (int i = 0; i < 3; i++) step(1, 1, OP_R, 6, 5, 5, 0, 0);
        ins(OP_R, 6, 5, 5);
        ins(OP_R, 6, 5, 5);
        idle(3);

        // Reset asserted mid-stall
        ins(OP_LOAD, 5, 1, 0);
        ins(OP_R, 6, 5, 5);
        step(0, 1, OP_R, 6, 5, 5, 0, 1);
        chk("rst_mid_stall", 32'(o_sif[1]), 32'd0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 85),
                 ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 80));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
